// File: rtl/fetch_stage_buffered_pkg.sv
// Shared fetch-stage definitions: machine word/instruction widths and fetch defaults.
package fetch_stage_buffered_pkg;

  localparam int unsigned WORD                 = 64;
  localparam int unsigned INSTR_LEN            = 32;
  localparam int unsigned FETCH_QDEPTH_DEFAULT = 4;
  localparam logic [WORD-1:0] RESET_PC_DEFAULT = '0;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of {pc, instr} pairs with push/pop/flush.
// Head entry is read combinationally; flush empties the queue and overrides push/pop.
module fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [PC_W-1:0]          push_pc,
  input  logic [INSTR_W-1:0]       push_instr,
  input  logic                     pop,
  output logic [PC_W-1:0]          head_pc,
  output logic [INSTR_W-1:0]       head_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign do_push    = push && !flush && !full;
  assign do_pop     = pop && !flush && !empty;
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Pointer/count bookkeeping and entry storage; storage is cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage_buffered.sv
// Decoupled instruction-fetch front end: one request per cycle to a 1-cycle-latency
// instruction memory, responses buffered in a prefetch queue drained by decode.
// A redirect flushes the queue, kills the in-flight read and restarts at the target.
module fetch_stage_buffered
  import fetch_stage_buffered_pkg::*;
#(
  parameter int unsigned       WORD_W   = WORD,
  parameter int unsigned       INSTR_W  = INSTR_LEN,
  parameter int unsigned       STEP     = 4,
  parameter logic [WORD_W-1:0] RESET_PC = WORD_W'(RESET_PC_DEFAULT),
  parameter int unsigned       QDEPTH   = FETCH_QDEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [WORD_W-1:0]  redirect_target,
  output logic               imem_req,
  output logic [WORD_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [WORD_W-1:0]  out_pc,
  output logic [WORD_W-1:0]  out_pc_next
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] fetch_pc_next;
  logic [WORD_W-1:0] pc_plus_step;
  logic [WORD_W-1:0] redirect_pc;
  logic              inflight;
  logic [WORD_W-1:0] inflight_pc;
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic              q_full;
  logic [CW:0]       occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  logic              unused_target_bits;

  // Redirect targets are word-aligned by discarding the low two bits.
  assign redirect_pc        = {redirect_target[WORD_W-1:2], 2'b00};
  assign unused_target_bits = ^redirect_target[1:0];
  assign pc_plus_step       = fetch_pc + WORD_W'(STEP);

  // Credit counts buffered entries plus the read in flight; a same-cycle pop is not credited.
  assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, inflight};
  assign issue     = !reset && !redirect_valid && !q_full && (occupancy < (CW+1)'(QDEPTH));

  assign push = inflight && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc;
  assign out_valid   = !q_empty;
  assign out_pc_next = out_pc + WORD_W'(STEP);

  // Next fetch PC: redirect wins, otherwise advance only when a request goes out.
  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
    end else if (issue) begin
      fetch_pc_next = pc_plus_step;
    end
  end

  // Fetch PC and in-flight read tracking; a redirect never issues, so it also kills inflight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      fetch_pc <= fetch_pc_next;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH   (QDEPTH),
    .PC_W    (WORD_W),
    .INSTR_W (INSTR_W)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (inflight_pc),
    .push_instr (imem_rdata),
    .pop        (pop),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .count      (q_count),
    .empty      (q_empty),
    .full       (q_full)
  );

endmodule

// File: tb/tb_fetch_stage_buffered.sv
// Self-checking bench for fetch_stage_buffered: directed vector table, hand-written
// redirect/wrap/async-reset sequences, and randomized traffic against a PC-queue model.
module tb_fetch_stage_buffered;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_pc_next;

  int passed = 0;
  int total  = 0;

  // Reference model: PCs requested since the last redirect/reset that decode has not taken.
  logic [63:0] pend[$];
  logic [63:0] m_pc;
  bit          m_last;

  typedef struct {
    bit          ready;
    bit          req;
    logic [63:0] addr;
    bit          valid;
    logic [63:0] pc;
  } vec_t;

  vec_t vecs[12];

  fetch_stage_buffered dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_next     (out_pc_next)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address a holds a>>2.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr[33:2];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_clear();
    pend.delete();
    m_pc   = 64'h0;
    m_last = 1'b0;
  endtask

  // Hold reset across edges, check reset outputs, release just after a rising edge.
  task automatic do_reset();
    reset           = 1'b1;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset imem_req", imem_req, 0);
    chk("reset out_pc", out_pc, 0);
    chk("reset out_instr", out_instr, 0);
    chk("reset out_pc_next", out_pc_next, 64'd4);
    @(posedge clk);
    #2 reset = 1'b0;
    model_clear();
  endtask

  // One cycle: drive at the falling edge, compare against the model, advance the model.
  task automatic step(input bit ready, input bit redir, input logic [63:0] tgt);
    bit ev;
    bit er;
    @(negedge clk);
    out_ready       = ready;
    redirect_valid  = redir;
    redirect_target = tgt;
    #1;
    ev = pend.size() > (m_last ? 1 : 0);
    er = !redir && (pend.size() < QD);
    chk("imem_req", imem_req, er);
    if (er) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_pc", out_pc, pend[0]);
      chk("out_instr", out_instr, {32'h0, pend[0][33:2]});
      chk("out_pc_next", out_pc_next, pend[0] + 64'd4);
    end
    if (redir) begin
      pend.delete();
      m_pc   = {tgt[63:2], 2'b00};
      m_last = 1'b0;
    end else begin
      if (ev && ready) void'(pend.pop_front());
      if (er) begin
        pend.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
      m_last = er;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] tgt;
    bit          rdy;
    bit          rd;

    // Backpressure from reset release, then drain: queue holds PCs 0..12, req stalls at 4.
    vecs[0]  = '{ready: 0, req: 1, addr: 64'd0,  valid: 0, pc: 64'd0};
    vecs[1]  = '{ready: 0, req: 1, addr: 64'd4,  valid: 0, pc: 64'd0};
    vecs[2]  = '{ready: 0, req: 1, addr: 64'd8,  valid: 1, pc: 64'd0};
    vecs[3]  = '{ready: 0, req: 1, addr: 64'd12, valid: 1, pc: 64'd0};
    vecs[4]  = '{ready: 0, req: 0, addr: 64'd0,  valid: 1, pc: 64'd0};
    vecs[5]  = '{ready: 0, req: 0, addr: 64'd0,  valid: 1, pc: 64'd0};
    vecs[6]  = '{ready: 1, req: 0, addr: 64'd0,  valid: 1, pc: 64'd0};
    vecs[7]  = '{ready: 1, req: 1, addr: 64'd16, valid: 1, pc: 64'd4};
    vecs[8]  = '{ready: 1, req: 1, addr: 64'd20, valid: 1, pc: 64'd8};
    vecs[9]  = '{ready: 1, req: 1, addr: 64'd24, valid: 1, pc: 64'd12};
    vecs[10] = '{ready: 1, req: 1, addr: 64'd28, valid: 1, pc: 64'd16};
    vecs[11] = '{ready: 1, req: 1, addr: 64'd32, valid: 1, pc: 64'd20};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      out_ready      = vecs[i].ready;
      redirect_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d imem_req", i), imem_req, vecs[i].req);
      if (vecs[i].req) chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].valid);
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].pc);
        chk($sformatf("vec%0d out_instr", i), out_instr, vecs[i].pc >> 2);
        chk($sformatf("vec%0d out_pc_next", i), out_pc_next, vecs[i].pc + 64'd4);
      end
    end

    // Redirect with three buffered entries and a read in flight.
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 64'h1000);
    step(1'b1, 1'b0, '0);
    chk("redirect first req addr", imem_addr, 64'h1000);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("redirect first out_pc", out_pc, 64'h1000);

    // Misaligned target is forced to a word boundary.
    step(1'b1, 1'b1, 64'h1003);
    step(1'b1, 1'b0, '0);
    chk("aligned redirect addr", imem_addr, 64'h1000);
    repeat (3) step(1'b1, 1'b0, '0);

    // Fetch PC wraps past the top of the address space.
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("wrap req addr", imem_addr, 64'h0);
    step(1'b1, 1'b0, '0);
    chk("wrap out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap out_pc_next", out_pc_next, 64'h0);
    repeat (3) step(1'b1, 1'b0, '0);

    // Async reset mid-cycle while streaming.
    chk("pre-reset out_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset imem_req", imem_req, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_clear();
    repeat (6) step(1'b1, 1'b0, '0);

    // Randomized traffic with backpressure and redirects.
    for (int n = 0; n < 600; n++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 24) == 0);
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      step(rdy, rd, tgt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
